// File: rtl/shift_sequencer.sv
// shift_sequencer
// Multi-cycle shift unit for the execute stage: shifts one bit per clock
// instead of using a combinational barrel shifter. Handles SLL/SRL/SRA with an
// immediate or register-sourced amount. busy stalls the pipeline until done.
//
// State table:
//   state   | meaning
//   S_IDLE  | waiting for start; result/carry hold the last completed value
//   S_SHIFT | shifting result one bit per cycle, count holds shifts remaining
//   S_DONE  | one-cycle completion pulse, result/carry valid
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   synchronous reset, active low
//   start      in   request, sampled only in S_IDLE
//   op         in   00 SLL, 01 SRL, 10 SRA, 11 pass-through
//   amt_sel    in   1 = shamt_imm, 0 = shamt_reg[SHW-1:0]
//   shamt_imm  in   immediate shift amount (unsigned)
//   shamt_reg  in   register shift amount, only low SHW bits used
//   operand    in   value to shift
//   result     out  shifted value, held until the next accepted start
//   carry      out  last bit shifted out, 0 when no shift occurred
//   zero       out  result == 0
//   busy       out  high in S_SHIFT and S_DONE
//   done       out  one-cycle completion pulse
module shift_sequencer #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic             amt_sel,
    input  logic [SHW-1:0]   shamt_imm,
    input  logic [WIDTH-1:0] shamt_reg,
    input  logic [WIDTH-1:0] operand,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             zero,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_SHIFT = 2'b01,
        S_DONE  = 2'b10
    } state_t;

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;
    localparam logic [1:0] OP_PASS = 2'b11;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             carry_q, carry_d;
    logic [SHW-1:0]   count_q, count_d;
    logic [1:0]       op_q, op_d;
    logic [SHW-1:0]   amt_sel_val;
    logic [SHW-1:0]   amt_start;

    // Upper register-amount bits are architecturally ignored.
    logic unused_shamt_hi;
    assign unused_shamt_hi = ^shamt_reg[WIDTH-1:SHW];

    assign amt_sel_val = amt_sel ? shamt_imm : shamt_reg[SHW-1:0];
    // Pass-through never shifts, whatever amount is presented.
    assign amt_start   = (op == OP_PASS) ? '0 : amt_sel_val;

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        carry_d  = carry_q;
        count_d  = count_q;
        op_d     = op_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    result_d = operand;
                    op_d     = op;
                    carry_d  = 1'b0;
                    count_d  = amt_start;
                    state_d  = (amt_start == '0) ? S_DONE : S_SHIFT;
                end
            end
            S_SHIFT: begin
                case (op_q)
                    OP_SLL: begin
                        carry_d  = result_q[WIDTH-1];
                        result_d = {result_q[WIDTH-2:0], 1'b0};
                    end
                    OP_SRL: begin
                        carry_d  = result_q[0];
                        result_d = {1'b0, result_q[WIDTH-1:1]};
                    end
                    OP_SRA: begin
                        carry_d  = result_q[0];
                        result_d = {result_q[WIDTH-1], result_q[WIDTH-1:1]};
                    end
                    default: begin
                        // Pass-through never reaches S_SHIFT; hold if it does.
                        carry_d  = carry_q;
                        result_d = result_q;
                    end
                endcase
                count_d = count_q - 1'b1;
                if (count_q == SHW'(1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            result_q <= '0;
            carry_q  <= 1'b0;
            count_q  <= '0;
            op_q     <= OP_SLL;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            carry_q  <= carry_d;
            count_q  <= count_d;
            op_q     <= op_d;
        end
    end

    assign result = result_q;
    assign carry  = carry_q;
    assign zero   = (result_q == '0);
    assign busy   = (state_q != S_IDLE);
    assign done   = (state_q == S_DONE);

endmodule

// File: tb/tb_shift_sequencer.sv
// Testbench for shift_sequencer: a cycle-timeline reference model (completion
// cycle = accept cycle + N, result from plain shift operators) checked every
// cycle, plus directed operations with hand-computed literal results.
module tb_shift_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic        amt_sel = 1'b0;
    logic [4:0]  shamt_imm = 5'd0;
    logic [31:0] shamt_reg = 32'd0;
    logic [31:0] operand = 32'd0;
    logic [31:0] result;
    logic        carry;
    logic        zero;
    logic        busy;
    logic        done;

    shift_sequencer #(.WIDTH(32), .SHW(5)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .amt_sel(amt_sel),
        .shamt_imm(shamt_imm), .shamt_reg(shamt_reg), .operand(operand),
        .result(result), .carry(carry), .zero(zero), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    int          cyc = 0;
    bit          m_act = 1'b0;
    int          m_end = 0;
    logic [31:0] m_res = 32'd0;
    logic        m_car = 1'b0;
    bit          chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic void model_calc(input logic [1:0] o, input logic [31:0] v, input int n,
                                       output logic [31:0] r, output logic c);
        case (o)
            2'b00: r = v << n;
            2'b01: r = v >> n;
            2'b10: r = $unsigned($signed(v) >>> n);
            default: r = v;
        endcase
        if (n == 0)       c = 1'b0;
        else if (o == 2'b00) c = v[32-n];
        else              c = v[n-1];
    endfunction

    // Timeline model: an op accepted at edge k is busy for cycles k..k+N and
    // signals done in cycle k+N (cycle index = number of edges seen).
    always @(posedge clk) begin
        int cur;
        bit idle;
        int n;
        cur  = cyc;
        idle = !(m_act && cur <= m_end);
        if (!rst) begin
            m_act = 1'b0;
            m_res = 32'd0;
            m_car = 1'b0;
        end else if (idle && start) begin
            n     = (op == 2'b11) ? 0 : int'(amt_sel ? shamt_imm : shamt_reg[4:0]);
            m_act = 1'b1;
            m_end = cur + 1 + n;
            model_calc(op, operand, n, m_res, m_car);
        end
        cyc = cur + 1;
    end

    always @(negedge clk) begin
        bit exp_busy;
        bit exp_done;
        if (chk_en) begin
            exp_busy = m_act && cyc <= m_end;
            exp_done = m_act && cyc == m_end;
            chk("busy", {31'd0, busy}, {31'd0, exp_busy});
            chk("done", {31'd0, done}, {31'd0, exp_done});
            if (!exp_busy || exp_done) begin
                chk("result", result, m_res);
                chk("carry", {31'd0, carry}, {31'd0, m_car});
                chk("zero", {31'd0, zero}, {31'd0, (m_res == 32'd0)});
            end
        end
    end

    task automatic do_op(input string name, input logic [1:0] o, input logic as,
                         input logic [4:0] imm, input logic [31:0] rg, input logic [31:0] opd,
                         input logic [31:0] exp_r, input logic exp_c, input int exp_lat,
                         input bit pulse_mid);
        int lat;
        @(negedge clk);
        start = 1'b1; op = o; amt_sel = as; shamt_imm = imm; shamt_reg = rg; operand = opd;
        @(negedge clk);
        start = 1'b0; op = 2'($urandom); amt_sel = 1'($urandom);
        shamt_imm = 5'($urandom); shamt_reg = $urandom; operand = $urandom;
        lat = 1;
        while (!done && lat < 64) begin
            @(negedge clk);
            lat++;
            if (pulse_mid && lat == 2) begin
                start = 1'b1; operand = 32'h0000_FFFF; op = 2'b01; amt_sel = 1'b1; shamt_imm = 5'd2;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        chk({name, "_latency"}, lat, exp_lat);
        chk({name, "_result"}, result, exp_r);
        chk({name, "_carry"}, {31'd0, carry}, {31'd0, exp_c});
        chk({name, "_zero"}, {31'd0, zero}, {31'd0, (exp_r == 32'd0)});
        @(negedge clk);
        chk({name, "_idle_busy"}, {31'd0, busy}, 32'd0);
        chk({name, "_idle_done"}, {31'd0, done}, 32'd0);
        chk({name, "_hold_result"}, result, exp_r);
    endtask

    initial begin
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        chk("reset_result", result, 32'd0);
        chk("reset_carry", {31'd0, carry}, 32'd0);
        chk("reset_zero", {31'd0, zero}, 32'd1);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        rst = 1'b1;

        do_op("sll4", 2'b00, 1'b1, 5'd4, 32'h0, 32'h0000_000F, 32'h0000_00F0, 1'b0, 5, 1'b0);
        do_op("sra_reg4", 2'b10, 1'b0, 5'd9, 32'hFFFF_FFE4, 32'h8000_0008, 32'hF800_0000, 1'b1, 5, 1'b0);
        do_op("srl31", 2'b01, 1'b1, 5'd31, 32'h0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 32, 1'b0);
        do_op("pass", 2'b11, 1'b1, 5'd7, 32'h0, 32'h0000_0000, 32'h0000_0000, 1'b0, 1, 1'b0);
        do_op("pass_nz", 2'b11, 1'b0, 5'd0, 32'h1F, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 1, 1'b0);
        do_op("start_ign", 2'b00, 1'b1, 5'd3, 32'h0, 32'h0000_0001, 32'h0000_0008, 1'b0, 4, 1'b1);
        do_op("sra31_neg", 2'b10, 1'b1, 5'd31, 32'h0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32, 1'b0);
        do_op("sll1", 2'b00, 1'b1, 5'd1, 32'h0, 32'h8000_0001, 32'h0000_0002, 1'b1, 2, 1'b0);

        // Reset in the third shift cycle of a 10-bit SLL.
        @(negedge clk);
        start = 1'b1; op = 2'b00; amt_sel = 1'b1; shamt_imm = 5'd10; operand = 32'h1234_5678;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_done", {31'd0, done}, 32'd0);
        chk("midrst_result", result, 32'd0);
        chk("midrst_zero", {31'd0, zero}, 32'd1);
        do_op("after_rst", 2'b01, 1'b1, 5'd8, 32'h0, 32'h1234_5678, 32'h0012_3456, 1'b0, 9, 1'b0);

        // Reset and start in the same cycle: reset wins.
        @(negedge clk);
        rst = 1'b0; start = 1'b1; op = 2'b00; amt_sel = 1'b1; shamt_imm = 5'd2; operand = 32'h5;
        @(negedge clk);
        rst = 1'b1; start = 1'b0;
        chk("rst_start_busy", {31'd0, busy}, 32'd0);
        chk("rst_start_result", result, 32'd0);

        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            rst       = ($urandom_range(0, 149) != 0);
            start     = ($urandom_range(0, 2) == 0);
            op        = 2'($urandom);
            amt_sel   = 1'($urandom);
            shamt_imm = 5'($urandom);
            shamt_reg = $urandom;
            operand   = ($urandom_range(0, 9) == 0) ? 32'd0 : $urandom;
        end
        @(negedge clk);
        rst = 1'b1; start = 1'b0;
        repeat (40) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/shift_sequencer.md
# shift_sequencer

Multi-cycle shift unit for the KGP-RISC execute stage. It handles the shift-class instructions: shll/shrl/shra with a 5-bit immediate shift amount, and shllv/shrlv/shrav with a register-sourced shift amount. It replaces a combinational barrel shifter with a one-bit-per-cycle FSM. It raises `busy` so the control unit stalls the pipeline until `done`.

## Interface
- `WIDTH`, 32, data width of operand and result
- `SHW`, 5, shift-amount width; must equal log2(WIDTH)

Ports:
- `clk`  in  1  system clock; all state changes on rising edge
- `rst`  in  1  synchronous, active-low reset
- `start`  in  1  request; sampled only in IDLE
- `op`  in  2  00 = SLL, 01 = SRL, 10 = SRA, 11 = reserved (pass-through)
- `amt_sel`  in  1  1 = use `shamt_imm`; 0 = use `shamt_reg[SHW-1:0]`
- `shamt_imm`  in  SHW  immediate shift amount, zero-extended (unsigned)
- `shamt_reg`  in  WIDTH  register shift amount; bits above SHW-1 ignored
- `operand`  in  WIDTH  value to shift
- `result`  out  WIDTH  shifted value; registered, held until next accepted start
- `carry`  out  1  last bit shifted out; 0 if no shift occurred
- `zero`  out  1  combinational (`result` == 0)
- `busy`  out  1  high in SHIFT and DONE states
- `done`  out  1  one-cycle completion pulse

## Operation
- States: IDLE, SHIFT, DONE.
- Reset (`rst` = 0 at a clock edge, any state) gives:
  - state IDLE
  - `result` = 0, `carry` = 0, `done` = 0, `busy` = 0, hence `zero` = 1
  - `count` = 0
- **IDLE with `start` = 1:**
  - Latch `operand` into `result` and latch `op`.
  - `count` = selected amount N (0..31). `op` = 11 forces N = 0.
  - Clear `carry`.
  - Next state is DONE if N = 0, else SHIFT.
- **IDLE with `start` = 0:** hold all registers.
- **SHIFT, each cycle:** shift `result` by one bit and decrement `count`.
  - SLL: `carry` ← result[WIDTH-1], result ← {result[WIDTH-2:0], 0}
  - SRL: `carry` ← result[0], result ← {0, result[WIDTH-1:1]}
  - SRA: `carry` ← result[0], result ← {result[WIDTH-1], result[WIDTH-1:1]}
  - When `count` = 1 (last shift), next state is DONE.
- **DONE:** `done` = 1 for exactly this cycle. Next state is IDLE unconditionally.
- `start` in SHIFT or DONE is ignored (not queued). The requester must wait for `busy` = 0.
- `operand`, `op` and shift amounts may change freely after the start cycle. Only the values latched at start matter.
- Width rules:
  - Shift amounts are unsigned; no sign-extension of `shamt_imm`.
  - SRA with N = 31 on a negative operand gives all ones.
  - No shift of 32 or more is possible.

## Timing
- Start accepted at edge k: for any N, `done` is high in the cycle after edge k+N.
- Latency is N+1 cycles from the start cycle: N = 0 gives 1 cycle; N = 31 gives 32 cycles.
- `busy` rises in the cycle after edge k and falls in the cycle after `done`.
- Earliest next accepted start is the first IDLE cycle, one cycle after `done`.
- `result`, `carry`, `zero` are valid while `done` = 1 and remain stable in IDLE until the next accepted start.
- Intermediate `result` values are visible during SHIFT and are not valid outputs.
- Reset asserted mid-SHIFT: state returns to IDLE at that edge, no `done` pulse, `result` cleared.
- Reset and `start` in the same cycle: reset wins.

## Test plan
- SLL, `amt_sel` = 1, `shamt_imm` = 4, `operand` = 0x0000_000F -> `result` = 0x0000_00F0, `carry` = 0, `done` 5 cycles after start cycle.
- SRA, `amt_sel` = 0, `shamt_reg` = 0xFFFF_FFE4 (low bits = 4), `operand` = 0x8000_0008 -> `result` = 0xF800_0000, `carry` = 1 (bit 3 shifted out last), latency 5.
- SRL, N = 31, `operand` = 0xFFFF_FFFF -> `result` = 0x0000_0001, `carry` = 1, `done` 32 cycles after start, `busy` high for 32 cycles.
- N = 0 and `op` = 11 with `shamt_imm` = 7, `operand` = 0 -> `result` = 0, `zero` = 1, `carry` = 0, `done` next cycle, `busy` high for 1 cycle.
- `start` pulsed again during SHIFT with a different operand -> ignored; first result completes unchanged, exactly one `done`.
- `rst` = 0 at third SHIFT cycle of an N = 10 SLL -> IDLE next cycle, `result` = 0, `busy` = 0, no `done`; a fresh start afterwards completes normally.
